// File: rtl/mode_switch_sync_pkg.sv
// Shared RTC definitions: mode bit positions, the mode FSM state encoding
// and the board-clock debounce length.
package mode_switch_sync_pkg;

   localparam int MODE_TIMER = 0;
   localparam int MODE_HOUR  = 1;
   localparam int MODE_DATE  = 2;

   // Roughly 20 ms of switch settling at the board clock.
   localparam int DEB_CYCLES_BOARD = 1_000_000;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACTIVE = 2'd1;
   localparam state_t ST_BREAK  = 2'd2;

endpackage

// File: rtl/mode_switch_sync_sw_debounce.sv
// Two-flop synchroniser followed by a whole-vector debounce: the switch
// vector is accepted only after it has been stable for DEB_CYCLES clocks.
module sw_debounce #(
   parameter int N_SW       = 3,
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_SW-1:0] sw_i,
   output logic [N_SW-1:0] deb_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic [N_SW-1:0]  meta_q;
   logic [N_SW-1:0]  sync_q;
   logic [N_SW-1:0]  cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic [N_SW-1:0]  deb_q,  deb_d;

   // Any difference restarts the count; the count saturates once the
   // candidate has been accepted, so deb simply keeps tracking cand.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      deb_d  = deb_q;
      if (sync_q != cand_q) begin
         cand_d = sync_q;
         cnt_d  = '0;
      end else if (cnt_q == CNT_MAX) begin
         deb_d = cand_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
         deb_q  <= '0;
      end else begin
         meta_q <= sw_i;
         sync_q <= meta_q;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         deb_q  <= deb_d;
      end
   end

   assign deb_o = deb_q;

endmodule

// File: rtl/mode_switch_sync.sv
// Programming-mode selector: debounced switches decoded to registered one-hot
// mode flags with lock, break-before-make sequencing and a change strobe.
module mode_switch_sync
   import mode_switch_sync_pkg::*;
#(
   parameter int N_SW       = 3,
   parameter int DEB_CYCLES = DEB_CYCLES_BOARD,
   parameter int CNT_W      = $clog2(DEB_CYCLES + 1),
   localparam int IDX_W     = (N_SW > 1) ? $clog2(N_SW) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SW-1:0]  sw,
   input  logic             lock,
   output logic [N_SW-1:0]  prog,
   output logic             prog_valid,
   output logic [IDX_W-1:0] mode_idx,
   output logic             mode_change
);

   logic [N_SW-1:0]  deb;
   logic [N_SW-1:0]  target;
   logic             single;

   state_t           state_q, state_d;
   logic [N_SW-1:0]  prog_q,  prog_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic             chg_q,   chg_d;

   sw_debounce #(
      .N_SW       (N_SW),
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .sw_i  (sw),
      .deb_o (deb)
   );

   // Several switches at once is as meaningless as none: both select no mode.
   assign single = (deb != '0) && ((deb & (deb - N_SW'(1))) == '0);
   assign target = single ? deb : '0;

   always_comb begin
      state_d = state_q;
      prog_d  = prog_q;
      chg_d   = 1'b0;
      if (!lock) begin
         case (state_q)
            ST_IDLE: begin
               if (target != '0) begin
                  prog_d  = target;
                  chg_d   = 1'b1;
                  state_d = ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (target != prog_q) begin
                  prog_d  = '0;
                  chg_d   = 1'b1;
                  state_d = (target == '0) ? ST_IDLE : ST_BREAK;
               end
            end
            ST_BREAK: begin
               if (target != '0) begin
                  prog_d  = target;
                  chg_d   = 1'b1;
                  state_d = ST_ACTIVE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               prog_d  = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Valid and index are derived from the next prog so all three register together.
   always_comb begin
      valid_d = (prog_d != '0);
      idx_d   = '0;
      for (int i = 0; i < N_SW; i++) begin
         if (prog_d[i]) begin
            idx_d = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         prog_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prog_q  <= prog_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         chg_q   <= chg_d;
      end
   end

   assign prog        = prog_q;
   assign prog_valid  = valid_q;
   assign mode_idx    = idx_q;
   assign mode_change = chg_q;

endmodule

// File: tb/tb_mode_switch_sync.sv
// Self-checking bench for mode_switch_sync with N_SW=3, DEB_CYCLES=4: exact
// cycle timing through a scoreboard queue plus a table of steady-state decodes.
module tb_mode_switch_sync;

   logic       clk;
   logic       reset;
   logic [2:0] sw;
   logic       lock;
   logic [2:0] prog;
   logic       prog_valid;
   logic [1:0] mode_idx;
   logic       mode_change;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int         cyc;
      logic [2:0] prog;
      logic       chg;
   } exp_t;

   exp_t sbq[$];

   typedef struct {
      logic [2:0] sw;
      logic [2:0] prog;
      logic       valid;
      logic [1:0] idx;
   } vec_t;

   vec_t vecs[7];

   mode_switch_sync #(
      .N_SW       (3),
      .DEB_CYCLES (4),
      .CNT_W      (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sw          (sw),
      .lock        (lock),
      .prog        (prog),
      .prog_valid  (prog_valid),
      .mode_idx    (mode_idx),
      .mode_change (mode_change)
   );

   // 10 ns clock; cyc counts rising edges so that at a falling edge it names
   // the edge whose results are currently visible.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h want=%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive inputs on the falling edge; the next rising edge samples them.
   task automatic applyStimulus(input logic [2:0] s, input logic l);
      @(negedge clk);
      sw   = s;
      lock = l;
   endtask

   task automatic pushExp(input int c, input logic [2:0] p, input logic m);
      exp_t e;
      e.cyc  = c;
      e.prog = p;
      e.chg  = m;
      sbq.push_back(e);
   endtask

   task automatic waitCycle(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 300 && sbq.size() > 0; i++) @(negedge clk);
      if (sbq.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: got=%0d pending want=0", sbq.size());
         sbq.delete();
      end
   endtask

   function automatic int expIdx(input logic [2:0] p);
      case (p)
         3'b010:  return 1;
         3'b100:  return 2;
         default: return 0;
      endcase
   endfunction

   // Scoreboard: pop every expectation due at this edge and compare, and at
   // every cycle confirm that two flags are never high together.
   always @(negedge clk) begin
      exp_t e;
      if (cyc >= 2 && !reset) begin
         total++;
         if (((prog & (prog - 3'd1)) != 3'd0) || (prog_valid != (prog != 3'd0))) begin
            bad++;
            $display("[TB] FAIL onehot: got prog=%b valid=%b want at most one flag and matching valid",
                     prog, prog_valid);
         end
      end
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         e = sbq.pop_front();
         checkOutput($sformatf("prog@%0d", e.cyc), int'(prog), int'(e.prog));
         checkOutput($sformatf("chg@%0d", e.cyc), int'(mode_change), int'(e.chg));
         checkOutput($sformatf("valid@%0d", e.cyc), int'(prog_valid), (e.prog != 3'b000) ? 1 : 0);
         checkOutput($sformatf("idx@%0d", e.cyc), int'(mode_idx), expIdx(e.prog));
      end
   end

   initial begin
      int t;
      int r;

      vecs[0] = '{sw: 3'b011, prog: 3'b000, valid: 1'b0, idx: 2'd0};
      vecs[1] = '{sw: 3'b010, prog: 3'b010, valid: 1'b1, idx: 2'd1};
      vecs[2] = '{sw: 3'b000, prog: 3'b000, valid: 1'b0, idx: 2'd0};
      vecs[3] = '{sw: 3'b110, prog: 3'b000, valid: 1'b0, idx: 2'd0};
      vecs[4] = '{sw: 3'b100, prog: 3'b100, valid: 1'b1, idx: 2'd2};
      vecs[5] = '{sw: 3'b111, prog: 3'b000, valid: 1'b0, idx: 2'd0};
      vecs[6] = '{sw: 3'b001, prog: 3'b001, valid: 1'b1, idx: 2'd0};

      // Reset held with an invalid switch combination.
      reset = 1'b1;
      sw    = 3'b111;
      lock  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_prog", int'(prog), 0);
      checkOutput("rst_valid", int'(prog_valid), 0);
      checkOutput("rst_idx", int'(mode_idx), 0);
      checkOutput("rst_chg", int'(mode_change), 0);
      reset = 1'b0;
      r = cyc;
      for (int c = r + 1; c <= r + 15; c++) pushExp(c, 3'b000, 1'b0);
      waitDrain();

      // Single select from idle lands exactly DEB_CYCLES+3 edges later.
      applyStimulus(3'b100, 1'b0);
      t = cyc + 1;
      for (int c = t; c <= t + 6; c++) pushExp(c, 3'b000, 1'b0);
      pushExp(t + 7, 3'b100, 1'b1);
      pushExp(t + 8, 3'b100, 1'b0);
      waitDrain();

      // Glitch of three cycles never reaches the mode flags.
      applyStimulus(3'b000, 1'b0);
      repeat (12) @(negedge clk);
      checkOutput("idle_prog", int'(prog), 0);
      applyStimulus(3'b010, 1'b0);
      t = cyc + 1;
      for (int c = t; c <= t + 15; c++) pushExp(c, 3'b000, 1'b0);
      waitCycle(t + 2);
      sw = 3'b000;
      waitDrain();

      // Break-before-make from timer to hour.
      applyStimulus(3'b001, 1'b0);
      repeat (12) @(negedge clk);
      checkOutput("pre_bbm_prog", int'(prog), 1);
      applyStimulus(3'b010, 1'b0);
      t = cyc + 1;
      for (int c = t; c <= t + 6; c++) pushExp(c, 3'b001, 1'b0);
      pushExp(t + 7, 3'b000, 1'b1);
      pushExp(t + 8, 3'b010, 1'b1);
      pushExp(t + 9, 3'b010, 1'b0);
      waitDrain();

      // Lock freezes the mode; the release applies the pending change.
      applyStimulus(3'b001, 1'b0);
      repeat (12) @(negedge clk);
      checkOutput("pre_lock_prog", int'(prog), 1);
      applyStimulus(3'b001, 1'b1);
      applyStimulus(3'b100, 1'b1);
      t = cyc + 1;
      for (int c = t; c <= t + 19; c++) pushExp(c, 3'b001, 1'b0);
      waitCycle(t + 19);
      lock = 1'b0;
      r = cyc;
      pushExp(r + 1, 3'b000, 1'b1);
      pushExp(r + 2, 3'b100, 1'b1);
      pushExp(r + 3, 3'b100, 1'b0);
      waitDrain();

      // Reset landing in the BREAK cycle discards the pending mode.
      applyStimulus(3'b001, 1'b0);
      repeat (12) @(negedge clk);
      checkOutput("pre_brk_prog", int'(prog), 1);
      applyStimulus(3'b100, 1'b0);
      t = cyc + 1;
      for (int c = t; c <= t + 6; c++) pushExp(c, 3'b001, 1'b0);
      pushExp(t + 7, 3'b000, 1'b1);
      pushExp(t + 8, 3'b000, 1'b0);
      for (int c = t + 9; c <= t + 15; c++) pushExp(c, 3'b000, 1'b0);
      pushExp(t + 16, 3'b100, 1'b1);
      pushExp(t + 17, 3'b100, 1'b0);
      waitCycle(t + 7);
      reset = 1'b1;
      waitCycle(t + 8);
      reset = 1'b0;
      waitDrain();

      // Steady-state decode table.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].sw, 1'b0);
         repeat (12) @(negedge clk);
         checkOutput($sformatf("vec%0d_prog", i), int'(prog), int'(vecs[i].prog));
         checkOutput($sformatf("vec%0d_valid", i), int'(prog_valid), int'(vecs[i].valid));
         checkOutput($sformatf("vec%0d_idx", i), int'(mode_idx), int'(vecs[i].idx));
         checkOutput($sformatf("vec%0d_chg", i), int'(mode_change), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
